accum_beta: RTL and testbench
=============================

ACCUM_BETA -- requirements
Module: accum_beta

Interface
REQ-001 SHALL have parameter DW, default 32, meaning data width of input samples and accumulated result.
REQ-002 SHALL have parameter LW, default 4, meaning width of group-length configuration.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port cfg_len  input  LW  samples per group; value 0 means 2^LW (16).
REQ-006 SHALL have port in_valid  input  1  upstream adder sum is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-008 SHALL have port in_data  input  DW  upstream adder sum (u_add_out & foo).
REQ-009 SHALL have port out_valid  output  1  accumulated group result is valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port out_data  output  DW  group sum, modulo 2^DW.
REQ-012 SHALL have port out_ovf  output  1  at least one carry-out of bit DW-1 occurred in the group.

Function
REQ-013 SHALL implement FSM states IDLE, ACC, HOLD.
REQ-014 SHALL transfer a sample only when in_valid and in_ready are both 1 on a rising edge.
REQ-015 SHALL drive in_ready = 1 in IDLE and ACC, and in_ready = out_ready in HOLD.
REQ-016 SHALL, on a transfer in IDLE, load acc = in_data, ovf = 0, cnt = 1, latch cfg_len into len_q, and go to ACC (or HOLD if len_q == 1).
REQ-017 SHALL, on a transfer in ACC, set acc = acc + in_data (DW-bit wrap), ovf |= carry, cnt += 1.
REQ-018 SHALL go from ACC to HOLD on the transfer that makes cnt equal len_q (0 decoded as 16).
REQ-019 SHALL ignore cfg_len changes while in ACC or HOLD; only len_q governs the current group.
REQ-020 SHALL assert out_valid only in HOLD, with out_data = acc and out_ovf = ovf held stable until out_ready.
REQ-021 SHALL have latency 1: out_valid rises in the cycle after the group's last sample is accepted.
REQ-022 SHALL, in HOLD with out_ready = 1 and no input transfer, go to IDLE.
REQ-023 SHALL, in HOLD with out_ready = 1 and a simultaneous input transfer, treat that sample as the first sample of the next group per REQ-016 (back-to-back, no bubble).
REQ-024 SHALL drop no sample and duplicate no result under any valid/ready combination.
REQ-025 SHALL keep in_valid = 1 with in_ready = 0 from causing any state change.

Reset
REQ-026 SHALL, while rst_n = 0, force state = IDLE, acc = 0, ovf = 0, cnt = 0, len_q = 0, out_valid = 0, out_data = 0, out_ovf = 0, in_ready = 1 once rst_n is 1.
REQ-027 SHALL abandon any partial group or pending result on reset mid-operation; the first transfer after release starts a new group.

Structure
REQ-028 SHALL place the state enum (IDLE/ACC/HOLD) and DW/LW default constants in shared package beta_pkg.
REQ-029 SHALL be a single module with no sub-modules; the adder is inline.

Verification
REQ-030 SHALL check cfg_len = 3, inputs 0x10, 0x20, 0x30 back-to-back, out_ready = 1 -> out_valid one cycle after third transfer, out_data = 0x60, out_ovf = 0.
REQ-031 SHALL check cfg_len = 2, inputs 0xFFFF_FFFF, 0x0000_0002 -> out_data = 0x0000_0001, out_ovf = 1.
REQ-032 SHALL check cfg_len = 0, sixteen inputs of 0x1 -> out_data = 0x10 after exactly 16 transfers.
REQ-033 SHALL check cfg_len = 1, out_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, out_data held at first sample; then out_ready = 1 with next sample 0x7 -> next result 0x7 with no idle cycle.
REQ-034 SHALL check cfg_len changed from 2 to 5 after the first transfer of a group -> group still closes after 2 samples.
REQ-035 SHALL check rst_n pulsed low after 2 of 4 samples -> all outputs 0, next 4 samples 0x1 each yield out_data = 0x4.

Source files
------------

// File: rtl/beta_pkg.sv
// beta_pkg: shared FSM state encoding and default widths for accum_beta
package beta_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int DEF_DW = 32;
   localparam int DEF_LW = 4;

endpackage

// File: rtl/accum_beta.sv
// accum_beta: sums groups of cfg_len samples and presents each group sum with a carry flag
module accum_beta
   import beta_pkg::*;
#(
   parameter int DW = DEF_DW,
   parameter int LW = DEF_LW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [LW-1:0] cfg_len,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_data,
   output logic          out_ovf
);

   state_t        r_state, w_state_nx;
   logic [DW-1:0] r_acc, w_acc_nx;
   logic          r_ovf, w_ovf_nx;
   logic [LW:0]   r_cnt, w_cnt_nx;
   logic [LW-1:0] r_len, w_len_nx;
   logic [LW:0]   w_len_dec;
   logic [LW:0]   w_cnt_inc;
   logic [DW:0]   w_sum;
   logic          w_xfer;

   // A zero length field encodes the full 2^LW group size
   assign w_len_dec = (r_len == '0) ? {1'b1, {LW{1'b0}}} : {1'b0, r_len};
   assign w_cnt_inc = r_cnt + (LW+1)'(1);
   assign w_sum     = {1'b0, r_acc} + {1'b0, in_data};
   assign in_ready  = (r_state == HOLD) ? out_ready : 1'b1;
   assign w_xfer    = in_valid & in_ready;
   assign out_valid = (r_state == HOLD);
   assign out_data  = r_acc;
   assign out_ovf   = r_ovf;

   // Next state and datapath; a transfer in IDLE or HOLD opens a fresh group
   always_comb begin
      w_state_nx = r_state;
      w_acc_nx   = r_acc;
      w_ovf_nx   = r_ovf;
      w_cnt_nx   = r_cnt;
      w_len_nx   = r_len;
      if (w_xfer && (r_state != ACC)) begin
         w_acc_nx   = in_data;
         w_ovf_nx   = 1'b0;
         w_cnt_nx   = (LW+1)'(1);
         w_len_nx   = cfg_len;
         w_state_nx = (cfg_len == LW'(1)) ? HOLD : ACC;
      end else if (w_xfer) begin
         w_acc_nx   = w_sum[DW-1:0];
         w_ovf_nx   = r_ovf | w_sum[DW];
         w_cnt_nx   = w_cnt_inc;
         w_state_nx = (w_cnt_inc == w_len_dec) ? HOLD : ACC;
      end else if ((r_state == HOLD) && out_ready) begin
         w_state_nx = IDLE;
      end
   end

   // State and datapath registers; reset discards any partial group or pending result
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_acc   <= '0;
         r_ovf   <= 1'b0;
         r_cnt   <= '0;
         r_len   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_acc   <= w_acc_nx;
         r_ovf   <= w_ovf_nx;
         r_cnt   <= w_cnt_nx;
         r_len   <= w_len_nx;
      end
   end

endmodule

// File: tb/tb_accum_beta.sv
// tb_accum_beta: directed checks of group accumulation, overflow, backpressure and reset
module tb_accum_beta;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  cfg_len;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_ovf;

   int n_vec = 0;
   int n_err = 0;

   accum_beta #(.DW(32), .LW(4)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cfg_len  (cfg_len),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_data  (in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_ovf  (out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [31:0] d);
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b0;
      cfg_len   = 4'd0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b1;
      #12;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_ovf", {31'd0, out_ovf}, 32'd0);
      rst_n = 1'b1;
      #1;
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk);
      #1;

      // three-sample group
      cfg_len = 4'd3;
      send(32'h10);
      send(32'h20);
      chk("g3_not_yet", {31'd0, out_valid}, 32'd0);
      send(32'h30);
      chk("g3_valid", {31'd0, out_valid}, 32'd1);
      chk("g3_data", out_data, 32'h60);
      chk("g3_ovf", {31'd0, out_ovf}, 32'd0);
      idle_cycle();
      chk("g3_drained", {31'd0, out_valid}, 32'd0);

      // carry out of the top bit
      cfg_len = 4'd2;
      send(32'hFFFF_FFFF);
      send(32'h0000_0002);
      chk("ovf_valid", {31'd0, out_valid}, 32'd1);
      chk("ovf_data", out_data, 32'h1);
      chk("ovf_flag", {31'd0, out_ovf}, 32'd1);
      idle_cycle();

      // length 0 decodes to 16
      cfg_len = 4'd0;
      for (int i = 0; i < 15; i++) send(32'h1);
      chk("g16_after15", {31'd0, out_valid}, 32'd0);
      send(32'h1);
      chk("g16_valid", {31'd0, out_valid}, 32'd1);
      chk("g16_data", out_data, 32'h10);
      chk("g16_ovf", {31'd0, out_ovf}, 32'd0);
      idle_cycle();

      // backpressure on a length-1 group, then back-to-back handoff
      cfg_len   = 4'd1;
      out_ready = 1'b0;
      send(32'hA5);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      in_data = 32'h7;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         @(posedge clk);
         #1;
         chk("bp_hold_data", out_data, 32'hA5);
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      send(32'h7);
      chk("b2b_valid", {31'd0, out_valid}, 32'd1);
      chk("b2b_data", out_data, 32'h7);
      idle_cycle();
      chk("b2b_drained", {31'd0, out_valid}, 32'd0);

      // cfg_len change mid-group is ignored
      cfg_len = 4'd2;
      send(32'h1);
      cfg_len = 4'd5;
      send(32'h2);
      chk("cfg_ignored_valid", {31'd0, out_valid}, 32'd1);
      chk("cfg_ignored_data", out_data, 32'h3);
      idle_cycle();

      // reset mid-group abandons partial sum
      cfg_len = 4'd4;
      send(32'h1);
      send(32'h1);
      in_valid = 1'b0;
      rst_n    = 1'b0;
      #2;
      chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_data", out_data, 32'd0);
      chk("mid_rst_ovf", {31'd0, out_ovf}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      send(32'h1);
      send(32'h1);
      send(32'h1);
      chk("post_rst_3", {31'd0, out_valid}, 32'd0);
      send(32'h1);
      chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
      chk("post_rst_data", out_data, 32'h4);
      idle_cycle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
